// File: rtl/pinaipple_bus_pkg.sv
// Shared types and defaults for the L1 device-port adapter.
// The default widths describe the standard device-port configuration.
package pinaipple_bus_pkg;

    localparam int unsigned NBR_HOSTS_LOG2_DEFAULT = 1;
    localparam int unsigned DATA_WIDTH_DEFAULT     = 32;
    localparam int unsigned ADDR_WIDTH_DEFAULT     = 20;

    typedef struct packed {
        logic [NBR_HOSTS_LOG2_DEFAULT-1:0] ini;
        logic                              is_write;
    } pend_entry_t;

    typedef struct packed {
        logic [NBR_HOSTS_LOG2_DEFAULT-1:0] ini;
        logic [DATA_WIDTH_DEFAULT-1:0]     rdata;
    } resp_entry_t;

    // Occupancy counters must be able to represent Depth itself, not just Depth-1.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pinaipple_sync_fifo.sv
// Small synchronous FIFO with registered storage; push and pop may happen in the
// same cycle even when full, the written slot being the one that is popped.
module pinaipple_sync_fifo
    import pinaipple_bus_pkg::*;
#(
    parameter type         T     = logic,
    parameter int unsigned Depth = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  T                       data_i,
    input  logic                   pop_i,
    output logic                   full_o,
    output logic                   empty_o,
    output T                       head_o,
    output logic [$clog2(Depth):0] count_o,
    output logic                   overflow_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth) + 1;

    T                mem_q [Depth];
    T                mem_d [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            pop_eff;
    logic            push_eff;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        pop_eff    = pop_i & ~empty_o;
        push_eff   = push_i & (~full_o | pop_eff);
        overflow_o = push_i & full_o & ~pop_eff;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push_eff) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop_eff) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        count_d = count_q + CntW'(push_eff) - CntW'(pop_eff);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && full_o && !pop_i));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        !(pop_i && empty_o));

endmodule

// File: rtl/pinaipple_dev_adapter.sv
// Device-side adapter: credit-based request acceptance, in-order tracking of the
// initiator of every access, and a response buffer that honours resp_ready_i.
module pinaipple_dev_adapter
    import pinaipple_bus_pkg::*;
#(
    parameter int unsigned DataWidth    = DATA_WIDTH_DEFAULT,
    parameter int unsigned AddrWidth    = ADDR_WIDTH_DEFAULT,
    parameter int unsigned NbrHostsLog2 = NBR_HOSTS_LOG2_DEFAULT,
    parameter int unsigned Depth        = 2,
    parameter bit          WriteResp    = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [NbrHostsLog2-1:0] req_ini_addr_i,
    input  logic [AddrWidth-1:0]    req_tgt_addr_i,
    input  logic                    req_wen_i,
    input  logic [DataWidth-1:0]    req_wdata_i,
    input  logic [DataWidth/8-1:0]  req_be_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [NbrHostsLog2-1:0] resp_ini_addr_o,
    output logic [DataWidth-1:0]    resp_rdata_o,
    output logic                    dev_req_o,
    output logic                    dev_we_o,
    output logic [DataWidth/8-1:0]  dev_be_o,
    output logic [31:0]             dev_addr_o,
    output logic [DataWidth-1:0]    dev_wdata_o,
    input  logic                    dev_rvalid_i,
    input  logic [DataWidth-1:0]    dev_rdata_i,
    output logic                    err_o
);

    localparam int unsigned CntW = cnt_width(Depth);

    typedef struct packed {
        logic [NbrHostsLog2-1:0] ini;
        logic                    is_write;
    } pend_t;

    typedef struct packed {
        logic [NbrHostsLog2-1:0] ini;
        logic [DataWidth-1:0]    rdata;
    } resp_t;

    pend_t           pend_in, pend_head;
    resp_t           resp_in, resp_head;
    logic            pend_full, pend_empty, pend_ovf;
    logic            resp_full, resp_empty, resp_ovf;
    logic [CntW-1:0] pend_cnt, resp_cnt, occ;
    logic            acc, cpl, stray, resp_push, resp_pop;
    logic            err_q, err_d;

    // Buffered responses hold credits too, so a stalled network throttles new requests.
    assign occ         = pend_cnt + resp_cnt;
    assign req_ready_o = (occ < CntW'(Depth));
    assign acc         = req_valid_i & req_ready_o;

    assign dev_req_o   = acc;
    assign dev_we_o    = req_wen_i;
    assign dev_be_o    = req_be_i;
    assign dev_addr_o  = 32'(req_tgt_addr_i);
    assign dev_wdata_o = req_wdata_i;

    always_comb begin
        pend_in.ini      = req_ini_addr_i;
        pend_in.is_write = req_wen_i;
        cpl              = dev_rvalid_i & ~pend_empty;
        stray            = dev_rvalid_i & pend_empty;
        resp_push        = cpl & (~pend_head.is_write | WriteResp);
        resp_in.ini      = pend_head.ini;
        resp_in.rdata    = pend_head.is_write ? '0 : dev_rdata_i;
        resp_pop         = resp_valid_o & resp_ready_i;
        err_d            = err_q | stray | pend_ovf | resp_ovf;
    end

    pinaipple_sync_fifo #(
        .T     (pend_t),
        .Depth (Depth)
    ) u_pend_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (acc),
        .data_i     (pend_in),
        .pop_i      (cpl),
        .full_o     (pend_full),
        .empty_o    (pend_empty),
        .head_o     (pend_head),
        .count_o    (pend_cnt),
        .overflow_o (pend_ovf)
    );

    pinaipple_sync_fifo #(
        .T     (resp_t),
        .Depth (Depth)
    ) u_resp_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (resp_push),
        .data_i     (resp_in),
        .pop_i      (resp_pop),
        .full_o     (resp_full),
        .empty_o    (resp_empty),
        .head_o     (resp_head),
        .count_o    (resp_cnt),
        .overflow_o (resp_ovf)
    );

    assign resp_valid_o    = ~resp_empty;
    assign resp_ini_addr_o = resp_head.ini;
    assign resp_rdata_o    = resp_head.rdata;
    assign err_o           = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    a_resp_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (resp_valid_o && !resp_ready_i) |=>
            (resp_valid_o && $stable(resp_rdata_o) && $stable(resp_ini_addr_o)));

    a_full_flags_consistent: assert property (@(posedge clk_i) disable iff (rst_i)
        !(pend_full && resp_full));

endmodule

// File: tb/tb_pinaipple_dev_adapter.sv
// Bench for two adapter configurations (Depth 4 with write beats, Depth 2 without)
// driven by shared requests and checked against a queue-level reference model.
module tb_pinaipple_dev_adapter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [0:0]  req_ini = '0;
    logic [19:0] req_addr = '0;
    logic        req_wen = 1'b0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        resp_ready = 1'b0;

    logic        req_ready  [2];
    logic        resp_valid [2];
    logic [0:0]  resp_ini   [2];
    logic [31:0] resp_rdata [2];
    logic        dev_req    [2];
    logic        dev_we     [2];
    logic [3:0]  dev_be     [2];
    logic [31:0] dev_addr   [2];
    logic [31:0] dev_wdata  [2];
    logic        dev_rvalid [2];
    logic [31:0] dev_rdata  [2];
    logic        err        [2];

    // Reference model: per-configuration circular queues of pending and response entries.
    int          p_ini [2][16];
    int          p_we  [2][16];
    int          p_hd  [2];
    int          p_n   [2];
    int          r_ini [2][16];
    logic [31:0] r_dat [2][16];
    int          r_hd  [2];
    int          r_n   [2];
    int          e_err [2];

    bit dev_auto = 1'b0;
    int dev_rate = 100;
    int errors   = 0;
    int checks   = 0;

    always #5 clk = ~clk;

    pinaipple_dev_adapter #(.DataWidth(32), .AddrWidth(20), .NbrHostsLog2(1), .Depth(4), .WriteResp(1'b1)) u_dut0 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready[0]), .req_ini_addr_i(req_ini),
        .req_tgt_addr_i(req_addr), .req_wen_i(req_wen), .req_wdata_i(req_wdata), .req_be_i(req_be),
        .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready), .resp_ini_addr_o(resp_ini[0]),
        .resp_rdata_o(resp_rdata[0]), .dev_req_o(dev_req[0]), .dev_we_o(dev_we[0]), .dev_be_o(dev_be[0]),
        .dev_addr_o(dev_addr[0]), .dev_wdata_o(dev_wdata[0]), .dev_rvalid_i(dev_rvalid[0]),
        .dev_rdata_i(dev_rdata[0]), .err_o(err[0])
    );

    pinaipple_dev_adapter #(.DataWidth(32), .AddrWidth(20), .NbrHostsLog2(1), .Depth(2), .WriteResp(1'b0)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready[1]), .req_ini_addr_i(req_ini),
        .req_tgt_addr_i(req_addr), .req_wen_i(req_wen), .req_wdata_i(req_wdata), .req_be_i(req_be),
        .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready), .resp_ini_addr_o(resp_ini[1]),
        .resp_rdata_o(resp_rdata[1]), .dev_req_o(dev_req[1]), .dev_we_o(dev_we[1]), .dev_be_o(dev_be[1]),
        .dev_addr_o(dev_addr[1]), .dev_wdata_o(dev_wdata[1]), .dev_rvalid_i(dev_rvalid[1]),
        .dev_rdata_i(dev_rdata[1]), .err_o(err[1])
    );

    function automatic int depth_of(input int k);
        return (k == 0) ? 4 : 2;
    endfunction

    function automatic bit write_resp_of(input int k);
        return (k == 0);
    endfunction

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            p_hd[k] = 0; p_n[k] = 0; r_hd[k] = 0; r_n[k] = 0; e_err[k] = 0;
        end
    endtask

    // Called at a falling edge with the request inputs already set.
    task automatic step();
        bit exp_rdy, acc;
        int ini, we;
        for (int k = 0; k < 2; k++) begin
            if (dev_auto) begin
                dev_rvalid[k] = (p_n[k] > 0) && ($urandom_range(99) < dev_rate);
                dev_rdata[k]  = $urandom;
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            exp_rdy = (p_n[k] + r_n[k]) < depth_of(k);
            acc     = req_valid && exp_rdy;
            check_val($sformatf("req_ready%0d", k), 64'(req_ready[k]), 64'(exp_rdy));
            check_val($sformatf("dev_req%0d", k), 64'(dev_req[k]), 64'(acc));
            check_val($sformatf("dev_addr%0d", k), 64'(dev_addr[k]), {44'd0, req_addr});
            check_val($sformatf("dev_pass%0d", k), {23'd0, dev_we[k], dev_be[k], dev_wdata[k], 4'd0},
                      {23'd0, req_wen, req_be, req_wdata, 4'd0});
            check_val($sformatf("resp_valid%0d", k), 64'(resp_valid[k]), 64'(r_n[k] > 0));
            check_val($sformatf("err%0d", k), 64'(err[k]), 64'(e_err[k]));
            if (r_n[k] > 0) begin
                check_val($sformatf("resp_ini%0d", k), 64'(resp_ini[k]), 64'(r_ini[k][r_hd[k]]));
                check_val($sformatf("resp_rdata%0d", k), 64'(resp_rdata[k]), 64'(r_dat[k][r_hd[k]]));
            end
            if (r_n[k] > 0 && resp_ready) begin
                r_hd[k] = (r_hd[k] + 1) % 16;
                r_n[k]--;
            end
            if (dev_rvalid[k]) begin
                if (p_n[k] > 0) begin
                    ini = p_ini[k][p_hd[k]];
                    we  = p_we[k][p_hd[k]];
                    p_hd[k] = (p_hd[k] + 1) % 16;
                    p_n[k]--;
                    if (we == 0 || write_resp_of(k)) begin
                        r_ini[k][(r_hd[k] + r_n[k]) % 16] = ini;
                        r_dat[k][(r_hd[k] + r_n[k]) % 16] = (we != 0) ? 32'd0 : dev_rdata[k];
                        r_n[k]++;
                    end
                end else begin
                    e_err[k] = 1;
                end
            end
            if (acc) begin
                p_ini[k][(p_hd[k] + p_n[k]) % 16] = int'(req_ini);
                p_we[k][(p_hd[k] + p_n[k]) % 16]  = int'(req_wen);
                p_n[k]++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input bit v, input bit ini, input bit wen, input logic [19:0] addr);
        req_valid = v;
        req_ini   = ini;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
    endtask

    task automatic set_dev(input bit v, input logic [31:0] data);
        dev_rvalid[0] = v; dev_rvalid[1] = v;
        dev_rdata[0]  = data; dev_rdata[1] = data;
    endtask

    task automatic drain(input int n);
        dev_auto = 1'b1; dev_rate = 100; resp_ready = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 20'h0);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        model_reset();
        set_dev(1'b0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_resp_valid0", 64'(resp_valid[0]), 64'd0);
        check_val("rst_resp_valid1", 64'(resp_valid[1]), 64'd0);
        check_val("rst_err0", 64'(err[0]), 64'd0);
        rst = 1'b0;

        // Single read: accept, device answers next cycle, beat the cycle after.
        dev_auto = 1'b0; resp_ready = 1'b1;
        set_req(1'b1, 1'b1, 1'b0, 20'h010); set_dev(1'b0, 32'h0); step();
        set_req(1'b0, 1'b0, 1'b0, 20'h0);   set_dev(1'b1, 32'hDEADBEEF); step();
        set_dev(1'b0, 32'h0); step();
        check_val("read_occ_free0", 64'(req_ready[0]), 64'd1);

        // Back-pressure: stalled network, reads until the Depth-2 port runs out of credits.
        dev_auto = 1'b1; dev_rate = 100; resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, 1'(i), 1'b0, 20'($urandom)); step();
        end
        set_req(1'b0, 1'b0, 1'b0, 20'h0);
        step();
        resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();

        // Writes: beat with zero data on one port, silent retirement on the other.
        set_req(1'b1, 1'b0, 1'b1, 20'h044); step();
        set_req(1'b1, 1'b1, 1'b1, 20'h048); step();
        drain(4);

        // Streaming reads with ids 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 1'(i), 1'b0, 20'(16 * i)); step();
        end
        drain(4);

        // Stray completion with nothing pending.
        dev_auto = 1'b0;
        set_dev(1'b1, 32'h12345678); step();
        set_dev(1'b0, 32'h0); step(); step();

        // Mixed random traffic; err stays sticky throughout.
        dev_auto = 1'b1; dev_rate = 60;
        for (int i = 0; i < 1500; i++) begin
            set_req($urandom_range(99) < 70, 1'($urandom), $urandom_range(99) < 30, 20'($urandom));
            resp_ready = $urandom_range(99) < 70;
            step();
        end

        // Reset with two pending and one buffered entry on the Depth-4 port.
        drain(8);
        dev_auto = 1'b0; resp_ready = 1'b0;
        set_req(1'b1, 1'b0, 1'b0, 20'h100); set_dev(1'b0, 32'h0); step();
        set_req(1'b1, 1'b1, 1'b0, 20'h104); set_dev(1'b1, 32'hCAFEF00D); step();
        set_req(1'b1, 1'b0, 1'b0, 20'h108); set_dev(1'b0, 32'h0); step();
        check_val("mid_pending0", 64'(p_n[0] == 2 && r_n[0] == 1), 64'(resp_valid[0] && !req_ready[1]));
        set_req(1'b0, 1'b0, 1'b0, 20'h0);
        rst = 1'b1;
        #1;
        check_val("rst_mid_resp_valid0", 64'(resp_valid[0]), 64'd0);
        check_val("rst_mid_err0", 64'(err[0]), 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        drain(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
